// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined main control for the 5-stage RISC-V core.
// Decodes ID, carries control through ID/EX, EX/MEM and MEM/WB, and holds EX for multi-cycle MULs.
module pipe_control_unit #(
    parameter int MUL_EN  = 1,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] Op_i,
    input  logic [6:0] Funct7_i,
    input  logic       NoOp_i,
    input  logic       Flush_i,
    output logic       Stall_o,
    output logic [1:0] ALUOp_EX_o,
    output logic       ALUSrc_EX_o,
    output logic       Branch_EX_o,
    output logic       Mul_EX_o,
    output logic       MemRead_MEM_o,
    output logic       MemWrite_MEM_o,
    output logic       RegWrite_WB_o,
    output logic       MemtoReg_WB_o
);
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       mul;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} state_t;

    ctrl_t             dec;
    ctrl_t             id_ex;
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              hold;
    logic              mem_read_mem, mem_write_mem, reg_write_mem, mem_to_reg_mem;
    logic              reg_write_wb, mem_to_reg_wb;

    always_comb begin
        dec = '0;
        case (Op_i)
            7'b0110011: begin
                dec.alu_op    = 2'b10;
                dec.reg_write = 1'b1;
                dec.mul       = (MUL_EN != 0) && (Funct7_i == 7'b0000001);
            end
            7'b0010011: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            7'b0000011: begin
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
            end
            7'b0100011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            7'b1100011: begin
                dec.alu_op = 2'b01;
                dec.branch = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    // A MUL entering EX stalls immediately; the counter tracks the remaining held cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        case (state)
            IDLE: if (id_ex.mul && MUL_LAT > 1) begin
                hold      = 1'b1;
                state_nxt = BUSY;
                cnt_nxt   = CNT_W'(MUL_LAT - 2);
            end
            BUSY: if (cnt != '0) begin
                hold    = 1'b1;
                cnt_nxt = cnt - 1'b1;
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            id_ex          <= '0;
            mem_read_mem   <= 1'b0;
            mem_write_mem  <= 1'b0;
            reg_write_mem  <= 1'b0;
            mem_to_reg_mem <= 1'b0;
            reg_write_wb   <= 1'b0;
            mem_to_reg_wb  <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            id_ex          <= hold ? id_ex : (Flush_i || NoOp_i) ? '0 : dec;
            mem_read_mem   <= !hold && id_ex.mem_read;
            mem_write_mem  <= !hold && id_ex.mem_write;
            reg_write_mem  <= !hold && id_ex.reg_write;
            mem_to_reg_mem <= !hold && id_ex.mem_to_reg;
            reg_write_wb   <= reg_write_mem;
            mem_to_reg_wb  <= mem_to_reg_mem;
        end
    end

    assign Stall_o        = hold;
    assign ALUOp_EX_o     = id_ex.alu_op;
    assign ALUSrc_EX_o    = id_ex.alu_src;
    assign Branch_EX_o    = id_ex.branch;
    assign Mul_EX_o       = id_ex.mul;
    assign MemRead_MEM_o  = mem_read_mem;
    assign MemWrite_MEM_o = mem_write_mem;
    assign RegWrite_WB_o  = reg_write_wb;
    assign MemtoReg_WB_o  = mem_to_reg_wb;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: three configurations (MUL 3-cycle, MUL disabled, MUL 1-cycle) driven in lockstep
// and checked every cycle against an occupancy-based pipeline model.
module tb_pipe_control_unit;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                           OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    typedef struct packed {
        logic [1:0] alu_op;
        logic alu_src, reg_write, mem_to_reg, mem_read, mem_write, branch, mul;
    } bnd_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [6:0] Op_i = '0, Funct7_i = '0;
    logic       NoOp_i = 1'b0, Flush_i = 1'b0;
    logic [9:0] obs [3];

    int checks = 0, failures = 0;
    int   cfg_en  [3] = '{1, 0, 1};
    int   cfg_lat [3] = '{3, 3, 1};
    bnd_t m_ex [3], m_mem [3], m_wb [3];
    int   m_left [3];

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [1:0] alu_op;
        logic stall, alu_src, branch, mul, mem_read, mem_write, reg_write, mem_to_reg;
        pipe_control_unit #(.MUL_EN(g == 1 ? 0 : 1), .MUL_LAT(g == 2 ? 1 : 3), .CNT_W(4)) dut (
            .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .Funct7_i(Funct7_i),
            .NoOp_i(NoOp_i), .Flush_i(Flush_i), .Stall_o(stall),
            .ALUOp_EX_o(alu_op), .ALUSrc_EX_o(alu_src), .Branch_EX_o(branch), .Mul_EX_o(mul),
            .MemRead_MEM_o(mem_read), .MemWrite_MEM_o(mem_write),
            .RegWrite_WB_o(reg_write), .MemtoReg_WB_o(mem_to_reg)
        );
        assign obs[g] = {stall, alu_op, alu_src, branch, mul, mem_read, mem_write, reg_write, mem_to_reg};
    end

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b (stall,aluop,alusrc,br,mul,mr,mw,rw,m2r)", tag, $time, got, exp);
        end
    endtask

    // ALUOp/ALUSrc/RegWrite/MemtoReg/MemRead/MemWrite/Branch table, plus the MUL flag
    function automatic bnd_t decode(input logic [6:0] op, input logic [6:0] f7, input int en);
        bnd_t b = '0;
        if (op == OP_R)   b = '{2'b10, 0, 1, 0, 0, 0, 0, (en != 0) && (f7 == F7_MUL)};
        if (op == OP_I)   b = '{2'b11, 1, 1, 0, 0, 0, 0, 0};
        if (op == OP_LW)  b = '{2'b00, 1, 1, 1, 1, 0, 0, 0};
        if (op == OP_SW)  b = '{2'b00, 1, 0, 0, 0, 1, 0, 0};
        if (op == OP_BEQ) b = '{2'b01, 0, 0, 0, 0, 0, 1, 0};
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_left[k] = 1;
        end
    endtask

    // EX keeps an instruction for m_left cycles; while it stays, a zero bundle flows into MEM
    task automatic model_edge(input logic [6:0] op, input logic [6:0] f7, input logic no, input logic fl);
        for (int k = 0; k < 3; k++) begin
            m_wb[k] = m_mem[k];
            if (m_left[k] > 1) begin
                m_mem[k] = '0;
                m_left[k]--;
            end else begin
                m_mem[k] = m_ex[k];
                m_ex[k] = (no || fl) ? bnd_t'('0) : decode(op, f7, cfg_en[k]);
                m_left[k] = m_ex[k].mul ? cfg_lat[k] : 1;
            end
        end
    endtask

    function automatic logic [9:0] expv(input int k);
        return {m_left[k] > 1, m_ex[k].alu_op, m_ex[k].alu_src, m_ex[k].branch, m_ex[k].mul,
                m_mem[k].mem_read, m_mem[k].mem_write, m_wb[k].reg_write, m_wb[k].mem_to_reg};
    endfunction

    task automatic compare_all(input string tag);
        for (int k = 0; k < 3; k++) chk($sformatf("%s[cfg%0d]", tag, k), obs[k], expv(k));
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic [6:0] f7, input logic no, input logic fl);
        Op_i = op; Funct7_i = f7; NoOp_i = no; Flush_i = fl;
        @(posedge clk_i);
        model_edge(op, f7, no, fl);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [6:0] op, f7;
        logic no, fl;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 compare_all("reset_held");
        @(negedge clk_i) rst_i = 1'b1;
        step("lw_ex", OP_LW, 7'd0, 0, 0);
        step("lw_mem", OP_BAD, 7'd0, 0, 0);
        step("lw_wb", OP_BAD, 7'd0, 0, 0);
        step("noop_r", OP_R, 7'd0, 1, 0);
        step("flush_beq", OP_BEQ, 7'd0, 0, 1);
        step("sw", OP_SW, 7'd0, 0, 0);
        step("i", OP_I, 7'd0, 0, 0);
        step("beq", OP_BEQ, 7'd0, 0, 0);
        step("drain", OP_BAD, 7'd0, 0, 0);
        step("drain", OP_BAD, 7'd0, 0, 0);
        step("mul_in", OP_R, F7_MUL, 0, 0);
        for (int i = 0; i < 5; i++) step("mul_run", OP_LW, 7'd0, 0, 0);
        step("mul_b2b", OP_R, F7_MUL, 0, 0);
        step("mul_b2b", OP_R, F7_MUL, 0, 0);
        for (int i = 0; i < 6; i++) step("mul_b2b_run", OP_BAD, 7'd0, 0, 0);
        step("mul_rst", OP_R, F7_MUL, 0, 0);
        #2 rst_i = 1'b0;
        model_reset();
        #1 compare_all("async_rst_busy");
        @(negedge clk_i) rst_i = 1'b1;
        step("post_rst_r", OP_R, 7'd0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            if (m_left[0] > 1) begin
                no = 1'b0; fl = 1'b0;
            end else begin
                case ($urandom_range(0, 7))
                    0: op = OP_R;   1: op = OP_I;  2: op = OP_LW;  3: op = OP_SW;
                    4: op = OP_BEQ; 5: op = OP_BAD; 6: op = 7'($urandom); default: op = OP_R;
                endcase
                f7 = ($urandom_range(0, 1) == 1) ? F7_MUL : 7'($urandom);
                no = ($urandom_range(0, 9) == 0);
                fl = ($urandom_range(0, 9) == 0);
            end
            step("rand", op, f7, no, fl);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
